// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: a small register-file instruction store behind
// a valid/ready request/response handshake, plus an independent program-load
// write port. One request is in flight at a time (IDLE -> READ -> RESP).
module instr_mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 17,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              rsp_ready,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_err,
    output logic [CNT_W-1:0]  rsp_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    // Full-width bound so out-of-range addresses never alias onto valid words.
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              addr_oob;
    logic              ld_oob;

    assign addr_oob  = (addr_q >= DEPTH_A);
    assign ld_oob    = (ld_addr >= DEPTH_A);
    assign req_ready = (state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic; RESP holds until the consumer takes the word.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = READ;
            READ:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read mux by full-address compare; no match yields zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_q == ADDR_W'(i)) rd_word = mem[i];
        end
    end

    // Instruction store: load port writes in any FSM state. The READ capture
    // samples the pre-edge word, so a same-cycle load returns the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (ld_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ld_addr == ADDR_W'(i)) mem[i] <= ld_data;
            end
        end
    end

    // Sticky load-error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 ld_err <= 1'b0;
        else if (ld_en && ld_oob) ld_err <= 1'b1;
    end

    // Request capture, response register and completion counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rsp_count <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) addr_q <= req_addr;
                READ: begin
                    rsp_data  <= addr_oob ? '0 : rd_word;
                    rsp_err   <= addr_oob;
                    rsp_valid <= 1'b1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rsp_count <= rsp_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized bench for instr_mem_responder against a word-array model of the
// instruction store, a sticky load-error bit and a modulo-256 completion count.
module tb_instr_mem_responder;

    localparam int DEPTH = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_err;
    logic [7:0]  rsp_count;

    instr_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err),
        .rsp_count(rsp_count)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [31:0] model [DEPTH];
    bit          lderr_m;
    logic [7:0]  cnt_m;
    int          vecs;
    int          errs;

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return (a < DEPTH) ? model[a] : 32'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        lderr_m = 0;
        cnt_m   = '0;
    endtask

    // One-cycle program-load write at an IDLE sample point.
    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 0;
        if (a < DEPTH) model[a] = d;
        else           lderr_m = 1;
    endtask

    // Drive one fetch transaction. ok reports handshake timing/stability;
    // d/e are the response captured on the first RESP cycle.
    task automatic do_fetch(input logic [31:0] a, input int hold, input bit coll,
                            input logic [31:0] cdata,
                            output logic [31:0] d, output logic e, output bit ok);
        logic [31:0] nd;
        ok = 1;
        if (req_ready !== 1'b1) ok = 0;
        req_valid = 1; req_addr = a;
        @(posedge clk); #1;
        req_valid = 0; req_addr = $urandom;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) ok = 0;
        if (coll) begin ld_en = 1; ld_addr = a; ld_data = cdata; end
        @(posedge clk); #1;
        ld_en = 0;
        if (coll && a < DEPTH) model[a] = cdata;
        if (rsp_valid !== 1'b1) ok = 0;
        d = rsp_data; e = rsp_err;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1; req_addr = $urandom_range(0, DEPTH - 1);
            if (a < DEPTH) begin
                nd = $urandom;
                ld_en = 1; ld_addr = a; ld_data = nd;
            end
            @(posedge clk); #1;
            if (ld_en) model[a] = nd;
            ld_en = 0;
            if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_err !== e || req_ready !== 1'b0) ok = 0;
        end
        req_valid = 0; rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        cnt_m = cnt_m + 8'd1;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) ok = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        model_clear();
        #12;
        vecs++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 32'h0 || rsp_err !== 1'b0 ||
            ld_err !== 1'b0 || rsp_count !== 8'h0) begin
            errs++;
            $display("FAIL reset_state: valid=%b ready=%b data=%h err=%b lderr=%b cnt=%0d, want 0 1 0 0 0 0",
                     rsp_valid, req_ready, rsp_data, rsp_err, ld_err, rsp_count);
        end
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] d, a, w; logic e; bit ok;
        do_load(32'd3, 32'hDEADBEEF);
        do_fetch(32'd3, 0, 0, 0, d, e, ok);
        vecs++;
        if (d !== 32'hDEADBEEF || e !== 1'b0 || !ok || rsp_count !== 8'd1) begin
            errs++;
            $display("FAIL basic_addr3: data=%h err=%b ok=%b cnt=%0d, want deadbeef 0 1 1", d, e, ok, rsp_count);
        end
        for (int i = 0; i < 24; i++) begin
            a = $urandom_range(0, DEPTH - 1);
            do_load(a, $urandom);
            a = $urandom_range(0, DEPTH + 3);
            w = exp_word(a);
            do_fetch(a, 0, 0, 0, d, e, ok);
            vecs++;
            if (d !== w || e !== (a >= DEPTH) || !ok || rsp_count !== cnt_m) begin
                errs++;
                $display("FAIL basic_rand a=%0d: data=%h err=%b ok=%b cnt=%0d, want %h %b 1 %0d",
                         a, d, e, ok, rsp_count, w, (a >= DEPTH), cnt_m);
            end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] addrs [4];
        logic [31:0] d, w; logic e; bit ok;
        addrs[0] = 32'd16; addrs[1] = 32'd17; addrs[2] = 32'h0001_0000; addrs[3] = 32'hFFFF_FFFF;
        do_load(32'd16, 32'hCAFE_0016);
        for (int i = 0; i < 4; i++) begin
            w = exp_word(addrs[i]);
            do_fetch(addrs[i], 0, 0, 0, d, e, ok);
            vecs++;
            if (d !== w || e !== (addrs[i] >= DEPTH) || !ok) begin
                errs++;
                $display("FAIL boundary a=%h: data=%h err=%b ok=%b, want %h %b 1",
                         addrs[i], d, e, ok, w, (addrs[i] >= DEPTH));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d, w, a; logic e; bit ok;
        for (int i = 0; i < 3; i++) begin
            a = $urandom_range(0, DEPTH - 1);
            do_load(a, $urandom);
            w = exp_word(a);
            do_fetch(a, 5 + i, 0, 0, d, e, ok);
            vecs++;
            if (d !== w || e !== 1'b0 || !ok || rsp_count !== cnt_m) begin
                errs++;
                $display("FAIL backpressure a=%0d: data=%h ok=%b cnt=%0d, want %h 1 %0d",
                         a, d, ok, rsp_count, w, cnt_m);
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] d; logic e; bit ok;
        do_load(32'd5, 32'h11);
        do_fetch(32'd5, 0, 1, 32'h22, d, e, ok);
        vecs++;
        if (d !== 32'h11 || e !== 1'b0 || !ok) begin
            errs++;
            $display("FAIL collision_old: data=%h ok=%b, want 00000011 1", d, ok);
        end
        do_fetch(32'd5, 0, 0, 0, d, e, ok);
        vecs++;
        if (d !== 32'h22 || !ok) begin
            errs++;
            $display("FAIL collision_new: data=%h ok=%b, want 00000022 1", d, ok);
        end
    endtask

    task automatic test_ld_err();
        logic [31:0] d, w; logic e; bit ok;
        vecs++;
        if (ld_err !== 1'b0) begin
            errs++;
            $display("FAIL ld_err_clear: got %b want 0", ld_err);
        end
        do_load(32'h20, $urandom);
        vecs++;
        if (ld_err !== lderr_m) begin
            errs++;
            $display("FAIL ld_err_set: got %b want %b", ld_err, lderr_m);
        end
        for (int i = 0; i < DEPTH; i++) begin
            w = exp_word(i);
            do_fetch(i, 0, 0, 0, d, e, ok);
            vecs++;
            if (d !== w || !ok) begin
                errs++;
                $display("FAIL ld_err_nowrite a=%0d: data=%h want %h", i, d, w);
            end
        end
        vecs++;
        if (ld_err !== 1'b1) begin
            errs++;
            $display("FAIL ld_err_sticky: got %b want 1", ld_err);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] d, w, pc; logic e; bit ok;
        pc = 0;
        for (int i = 0; i < 270; i++) begin
            w = exp_word(pc);
            do_fetch(pc, 0, 0, 0, d, e, ok);
            vecs++;
            if (d !== w || e !== 1'b0 || !ok || rsp_count !== cnt_m) begin
                errs++;
                $display("FAIL sweep pc=%0d: data=%h ok=%b cnt=%0d, want %h 1 %0d",
                         pc, d, ok, rsp_count, w, cnt_m);
            end
            pc = (pc == DEPTH - 1) ? 0 : pc + 1;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; bit ok;
        do_load(32'd7, 32'h7777_7777);
        req_valid = 1; req_addr = 32'd7;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        vecs++;
        if (rsp_valid !== 1'b1) begin
            errs++;
            $display("FAIL mid_resp_reached: valid=%b want 1", rsp_valid);
        end
        rst = 0;
        model_clear();
        #2;
        vecs++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_count !== 8'h0 || ld_err !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset: valid=%b ready=%b cnt=%0d lderr=%b, want 0 1 0 0",
                     rsp_valid, req_ready, rsp_count, ld_err);
        end
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            do_fetch(32'd3 + 32'(i * 2), 0, 0, 0, d, e, ok);
            vecs++;
            if (d !== 32'h0 || !ok || rsp_count !== cnt_m) begin
                errs++;
                $display("FAIL post_reset_read a=%0d: data=%h cnt=%0d, want 0 %0d", 3 + i * 2, d, rsp_count, cnt_m);
            end
        end
    endtask

    initial begin
        vecs = 0; errs = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_collision();
        test_ld_err();
        test_sweep();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
